// File: rtl/time_ctrl_pkg.sv
// Shared definitions for the front-panel time-set controller: state encoding,
// datapath mode codes, per-field maximum values and the wrapping edit step.
package time_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  localparam logic [1:0] MODE_RUN = 2'd0;
  localparam logic [1:0] MODE_SEC = 2'd1;
  localparam logic [1:0] MODE_MIN = 2'd2;
  localparam logic [1:0] MODE_HR  = 2'd3;

  localparam logic [5:0] MAX_HR  = 6'd23;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [5:0] MAX_SEC = 6'd59;

  // One edit step on a field, wrapping max->0 going up and 0->max going down.
  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] max_v,
                                            input logic       inc);
    if (inc) return (v == max_v) ? 6'd0 : v + 6'd1;
    else     return (v == 6'd0) ? max_v : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_controller_btn_conditioner.sv
// Raw push-button conditioner: 2-FF synchroniser, counting debouncer, rising-edge
// press pulse and an optional hold-to-repeat pulse train.
module btn_conditioner #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int REPEAT_EN    = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int TW   = $clog2(TMAX + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse_q, pulse_d;
  logic          rise, fire;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce, press detection and repeat timing; the timer runs only while held.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = '0;
    timer_d = timer_q;
    fire    = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) deb_d = sync2_q;
      else                              cnt_d = cnt_q + 1'b1;
    end
    rise = deb_d & ~deb_q;
    if (REPEAT_EN != 0) begin
      if (rise) begin
        timer_d = TW'(REPEAT_DELAY - 1);
      end else if (deb_q && deb_d) begin
        if (timer_q == '0) begin
          fire    = 1'b1;
          timer_d = TW'(REPEAT_RATE - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end else begin
        timer_d = '0;
      end
    end
    pulse_d = rise | fire;
  end

  // Conditioner state register; reset returns the button to released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      timer_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/time_set_controller.sv
// Front-panel time-set controller: field-select FSM, wrapped edit registers and
// blink strobe feeding the time-entry datapath.
module time_set_controller
  import time_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       run_en,
  output logic [1:0] mode,
  output logic [5:0] val,
  output logic       switch,
  output logic       visible
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic          mode_p, up_p, down_p;
  state_t        state_q, state_d;
  logic [5:0]    hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [1:0]    mode_q, mode_d;
  logic [5:0]    val_q, val_d;
  logic          run_q, run_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          vis_q, vis_d;
  logic          edit;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(0))
    u_btn_mode (.clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .pulse(mode_p));

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1))
    u_btn_up (.clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .pulse(up_p));

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1))
    u_btn_down (.clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .pulse(down_p));

  // Edit the field being left first, then advance; outputs follow the new state.
  always_comb begin
    state_d = state_q;
    hr_d    = hr_q;
    min_d   = min_q;
    sec_d   = sec_q;
    edit    = (state_q != ST_RUN) && (up_p ^ down_p);
    case (state_q)
      ST_SET_HR:  if (edit) hr_d  = step_field(hr_q,  MAX_HR,  up_p);
      ST_SET_MIN: if (edit) min_d = step_field(min_q, MAX_MIN, up_p);
      ST_SET_SEC: if (edit) sec_d = step_field(sec_q, MAX_SEC, up_p);
      default: ;
    endcase
    if (mode_p) begin
      case (state_q)
        ST_RUN:     state_d = ST_SET_HR;
        ST_SET_HR:  state_d = ST_SET_MIN;
        ST_SET_MIN: state_d = ST_SET_SEC;
        default:    state_d = ST_RUN;
      endcase
    end
    case (state_d)
      ST_SET_HR:  begin mode_d = MODE_HR;  val_d = hr_d;  end
      ST_SET_MIN: begin mode_d = MODE_MIN; val_d = min_d; end
      ST_SET_SEC: begin mode_d = MODE_SEC; val_d = sec_d; end
      default:    begin mode_d = MODE_RUN; val_d = 6'd0;  end
    endcase
    run_d = (state_d == ST_RUN);
    if (state_d == ST_RUN || state_d != state_q || edit) begin
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (blink_q == BW'(BLINK_CYCLES - 1)) begin
      blink_d = '0;
      vis_d   = ~vis_q;
    end else begin
      blink_d = blink_q + 1'b1;
      vis_d   = vis_q;
    end
  end

  // Controller state register; run_q stays low during reset so switch is held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      hr_q    <= 6'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      mode_q  <= MODE_RUN;
      val_q   <= 6'd0;
      run_q   <= 1'b0;
      blink_q <= '0;
      vis_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hr_q    <= hr_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      run_q   <= run_d;
      blink_q <= blink_d;
      vis_q   <= vis_d;
    end
  end

  assign mode    = mode_q;
  assign val     = val_q;
  assign switch  = run_en & run_q;
  assign visible = vis_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller with small timing parameters.
module tb_time_set_controller;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       run_en = 1'b1;
  logic [1:0] mode;
  logic [5:0] val;
  logic       switch;
  logic       visible;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int kind;      // 0 = mode, 1 = up, 2 = down
    int count;
    int exp_mode;
    int exp_val;
    int exp_sw;
  } vec_t;

  vec_t vecs[8];

  // reference model: field 0=RUN 1=HR 2=MIN 3=SEC
  int m_field;
  int m_vals[4];
  int m_max[4];
  int m_mode_code[4];

  time_set_controller #(.DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
                        .BLINK_CYCLES(BLK)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .btn_down(btn_down), .run_en(run_en), .mode(mode), .val(val),
    .switch(switch), .visible(visible));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // A clean press of the selected buttons, long enough to debounce both edges.
  task automatic applyStimulus(input bit m, input bit u, input bit d);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic holdUp(input int n);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (n) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Press up until val changes (bounded), leaving the bench just after the edit edge.
  task automatic upUntilChange();
    int prev;
    bit found;
    @(negedge clk);
    prev = int'(val);
    found = 1'b0;
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (int'(val) != prev) begin
        found = 1'b1;
        break;
      end
    end
    btn_up = 1'b0;
    checkOutput("edit_seen", int'(found), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic modelInit();
    m_field = 0;
    for (int i = 0; i < 4; i++) m_vals[i] = 0;
  endtask

  task automatic modelPress(input bit m, input bit u, input bit d);
    if (m_field != 0 && (u != d)) begin
      if (u) m_vals[m_field] = (m_vals[m_field] + 1) % (m_max[m_field] + 1);
      else   m_vals[m_field] = (m_vals[m_field] + m_max[m_field]) % (m_max[m_field] + 1);
    end
    if (m) m_field = (m_field + 1) % 4;
  endtask

  initial begin
    m_max[0] = 0;  m_max[1] = 23; m_max[2] = 59; m_max[3] = 59;
    m_mode_code[0] = 0; m_mode_code[1] = 3; m_mode_code[2] = 2; m_mode_code[3] = 1;

    vecs[0] = '{kind: 0, count: 1,  exp_mode: 3, exp_val: 0,  exp_sw: 0};
    vecs[1] = '{kind: 1, count: 23, exp_mode: 3, exp_val: 23, exp_sw: 0};
    vecs[2] = '{kind: 1, count: 1,  exp_mode: 3, exp_val: 0,  exp_sw: 0};
    vecs[3] = '{kind: 0, count: 1,  exp_mode: 2, exp_val: 0,  exp_sw: 0};
    vecs[4] = '{kind: 2, count: 1,  exp_mode: 2, exp_val: 59, exp_sw: 0};
    vecs[5] = '{kind: 0, count: 2,  exp_mode: 0, exp_val: 0,  exp_sw: 1};
    vecs[6] = '{kind: 0, count: 1,  exp_mode: 3, exp_val: 0,  exp_sw: 0};
    vecs[7] = '{kind: 0, count: 2,  exp_mode: 1, exp_val: 0,  exp_sw: 0};

    // reset state with run_en high
    run_en = 1'b1;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_mode", int'(mode), 0);
    checkOutput("rst_val", int'(val), 0);
    checkOutput("rst_switch", int'(switch), 0);
    checkOutput("rst_visible", int'(visible), 1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("release_switch", int'(switch), 1);

    // table of press sequences
    for (int v = 0; v < 8; v++) begin
      for (int c = 0; c < vecs[v].count; c++)
        applyStimulus(vecs[v].kind == 0, vecs[v].kind == 1, vecs[v].kind == 2);
      checkOutput($sformatf("vec%0d_mode", v), int'(mode), vecs[v].exp_mode);
      checkOutput($sformatf("vec%0d_val", v), int'(val), vecs[v].exp_val);
      checkOutput($sformatf("vec%0d_switch", v), int'(switch), vecs[v].exp_sw);
    end

    // glitch shorter than the debounce window, then a real press
    holdUp(3);
    checkOutput("glitch_val", int'(val), 0);
    holdUp(6);
    checkOutput("short_press_val", int'(val), 1);

    // down twice: 1 -> 0 -> 59
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("down_wrap_val", int'(val), 59);

    // hold long enough for the press plus three repeats: 59 -> 0,1,2,3
    holdUp(34);
    checkOutput("repeat_val", int'(val), 3);
    checkOutput("repeat_mode", int'(mode), 1);

    // blink timing relative to the edit edge
    upUntilChange();
    checkOutput("blink_edit_val", int'(val), 4);
    checkOutput("blink_start", int'(visible), 1);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 7)  checkOutput("blink_k7",  int'(visible), 1);
      if (k == 8)  checkOutput("blink_k8",  int'(visible), 0);
      if (k == 15) checkOutput("blink_k15", int'(visible), 0);
      if (k == 16) checkOutput("blink_k16", int'(visible), 1);
      if (k == 24) checkOutput("blink_k24", int'(visible), 0);
    end
    upUntilChange();
    checkOutput("edit_restart_vis", int'(visible), 1);
    checkOutput("edit_restart_val", int'(val), 5);

    // reset in the middle of a press
    @(negedge clk);
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_mode", int'(mode), 0);
    checkOutput("midrst_val", int'(val), 0);
    checkOutput("midrst_switch", int'(switch), 0);
    checkOutput("midrst_visible", int'(visible), 1);
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_release_switch", int'(switch), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sec_lost_mode", int'(mode), 1);
    checkOutput("sec_lost_val", int'(val), 0);

    // randomized presses against the reference model
    doReset();
    modelInit();
    for (int it = 0; it < 40; it++) begin
      int act;
      bit m, u, d;
      act = int'($urandom_range(0, 6));
      run_en = 1'($urandom_range(0, 1));
      m = (act == 0) || (act == 5);
      u = (act == 1) || (act == 3) || (act == 4) || (act == 5);
      d = (act == 2) || (act == 3) || (act == 6);
      if (act == 4) u = 1'b1;
      applyStimulus(m, u, d);
      modelPress(m, u, d);
      checkOutput($sformatf("rnd%0d_mode", it), int'(mode), m_mode_code[m_field]);
      checkOutput($sformatf("rnd%0d_val", it), int'(val),
                  (m_field == 0) ? 0 : m_vals[m_field]);
      checkOutput($sformatf("rnd%0d_switch", it), int'(switch),
                  (run_en && m_field == 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
